// File: rtl/sw_debounce8_if.sv
// rtl/sw_debounce8_if.sv - switch debouncer signal bundle; rise exists only with SW_DEBOUNCE_RISE_EN
interface sw_debounce8_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] sw_in;
    logic [WIDTH-1:0] sw_out;
    logic             chg;
`ifdef SW_DEBOUNCE_RISE_EN
    logic [WIDTH-1:0] rise;

    modport master (output sw_in, input sw_out, input chg, input rise);
    modport slave  (input sw_in, output sw_out, output chg, output rise);
`else
    modport master (output sw_in, input sw_out, input chg);
    modport slave  (input sw_in, output sw_out, output chg);
`endif
endinterface

// File: rtl/sw_debounce8.sv
// rtl/sw_debounce8.sv - per-bit tick-sampled switch debouncer; optional rise pulses with SW_DEBOUNCE_RISE_EN
module sw_debounce8 #(
    parameter int WIDTH  = 8,
    parameter int DIV    = 50000,
    parameter int STABLE = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    sw_debounce8_if.slave  io
);
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CW = $clog2(STABLE + 1);
    localparam logic [PW-1:0] PLAST = PW'(DIV - 1);
    localparam logic [CW-1:0] CLAST = CW'(STABLE - 1);

    typedef enum logic {ST_MATCH, ST_COUNT} state_e;

    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;
    logic [PW-1:0]    pcnt_q;
    logic [PW-1:0]    pcnt_d;
    state_e           state_q [WIDTH];
    state_e           state_d [WIDTH];
    logic [CW-1:0]    cnt_q   [WIDTH];
    logic [CW-1:0]    cnt_d   [WIDTH];
    logic [WIDTH-1:0] sw_out_q;
    logic [WIDTH-1:0] sw_out_d;
    logic [WIDTH-1:0] accept;
    logic             chg_q;
    logic             chg_d;
    logic             tick;
`ifdef SW_DEBOUNCE_RISE_EN
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] rise_d;
`endif

    assign tick = (pcnt_q == PLAST);

    always_comb begin
        pcnt_d   = tick ? '0 : pcnt_q + PW'(1);
        sw_out_d = sw_out_q;
        accept   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            if (tick) begin
                if (s2_q[i] == sw_out_q[i]) begin
                    state_d[i] = ST_MATCH;
                    cnt_d[i]   = '0;
                end else if (cnt_q[i] != CLAST) begin
                    // cnt is 0 in MATCH, so CLAST==0 (STABLE==1) accepts on the first differing tick
                    state_d[i] = ST_COUNT;
                    cnt_d[i]   = (state_q[i] == ST_MATCH) ? CW'(1) : cnt_q[i] + CW'(1);
                end else begin
                    state_d[i]  = ST_MATCH;
                    cnt_d[i]    = '0;
                    sw_out_d[i] = s2_q[i];
                    accept[i]   = 1'b1;
                end
            end
        end
        chg_d = |accept;
`ifdef SW_DEBOUNCE_RISE_EN
        rise_d = accept & s2_q;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q     <= '0;
            s2_q     <= '0;
            pcnt_q   <= '0;
            sw_out_q <= '0;
            chg_q    <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                state_q[i] <= ST_MATCH;
                cnt_q[i]   <= '0;
            end
`ifdef SW_DEBOUNCE_RISE_EN
            rise_q   <= '0;
`endif
        end else begin
            s1_q     <= io.sw_in;
            s2_q     <= s1_q;
            pcnt_q   <= pcnt_d;
            sw_out_q <= sw_out_d;
            chg_q    <= chg_d;
            for (int i = 0; i < WIDTH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
`ifdef SW_DEBOUNCE_RISE_EN
            rise_q   <= rise_d;
`endif
        end
    end

    assign io.sw_out = sw_out_q;
    assign io.chg    = chg_q;
`ifdef SW_DEBOUNCE_RISE_EN
    assign io.rise   = rise_q;
`endif
endmodule

// File: tb/tb_sw_debounce8.sv
// tb/tb_sw_debounce8.sv - directed bench for sw_debounce8 at DIV=4, STABLE=3
module tb_sw_debounce8;
    localparam int W      = 8;
    localparam int DIV    = 4;
    localparam int STABLE = 3;

    logic clk = 1'b0;
    logic rst_n;
    int   nvec = 0;
    int   nerr = 0;

    sw_debounce8_if #(.WIDTH(W)) bus ();

    sw_debounce8 #(.WIDTH(W), .DIV(DIV), .STABLE(STABLE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic settle(input logic [7:0] v, output bit ok);
        ok = 1'b0;
        bus.sw_in = v;
        for (int c = 0; c < 40 && !ok; c++) begin
            step();
            if (bus.sw_out === v) ok = 1'b1;
        end
        repeat (6) step();
    endtask

    function automatic logic [2:0] enc8(input logic [7:0] x);
        enc8 = 3'd0;
        for (int i = 0; i < 8; i++) if (x[i]) enc8 = 3'(i);
    endfunction

    task automatic test_reset();
        int first  = -1;
        int pulses = 0;
        rst_n = 1'b0;
        bus.sw_in = 8'hFF;
        for (int c = 0; c < 6; c++) begin
            step();
            nvec++;
            if (bus.sw_out !== 8'h00 || bus.chg !== 1'b0) begin
                nerr++;
                $display("FAIL reset_hold: sw_out=%h chg=%b required sw_out=00 chg=0", bus.sw_out, bus.chg);
            end
`ifdef SW_DEBOUNCE_RISE_EN
            nvec++;
            if (bus.rise !== 8'h00) begin
                nerr++;
                $display("FAIL reset_rise: rise=%h required 00", bus.rise);
            end
`endif
        end
        rst_n = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (bus.chg === 1'b1) pulses++;
            if (first < 0 && bus.sw_out === 8'hFF) begin
                first = c;
                nvec++;
                if (bus.chg !== 1'b1) begin
                    nerr++;
                    $display("FAIL reset_chg_coincident: chg=%b required 1", bus.chg);
                end
            end
        end
        nvec++;
        if (first != 12) begin
            nerr++;
            $display("FAIL reset_latency: cycles=%0d required 12", first);
        end
        nvec++;
        if (pulses != 1) begin
            nerr++;
            $display("FAIL reset_chg_count: pulses=%0d required 1", pulses);
        end
    endtask

    task automatic test_clean_step();
        bit ok;
        int first = -1, pulses = 0, pulse_at = -1, changes = 0;
        logic [7:0] prev;
        settle(8'h00, ok);
        nvec++;
        if (!ok) begin
            nerr++;
            $display("FAIL step_settle: sw_out=%h required 00", bus.sw_out);
        end
        prev = bus.sw_out;
        bus.sw_in = 8'h01;
        for (int c = 1; c <= 40; c++) begin
            step();
            if (bus.chg === 1'b1) begin pulses++; pulse_at = c; end
            if (bus.sw_out !== prev) begin
                changes++;
                if (first < 0) first = c;
            end
            prev = bus.sw_out;
        end
        nvec++;
        if (first < 11 || first > 14) begin
            nerr++;
            $display("FAIL step_latency: cycles=%0d required 11..14", first);
        end
        nvec++;
        if (bus.sw_out !== 8'h01) begin
            nerr++;
            $display("FAIL step_value: sw_out=%h required 01", bus.sw_out);
        end
        nvec++;
        if (pulses != 1 || pulse_at != first) begin
            nerr++;
            $display("FAIL step_chg: pulses=%0d at=%0d required 1 at %0d", pulses, pulse_at, first);
        end
        nvec++;
        if (changes != 1) begin
            nerr++;
            $display("FAIL step_changes: changes=%0d required 1", changes);
        end
    endtask

    task automatic test_glitch();
        bit ok;
        int bad_out = 0, bad_chg = 0;
        settle(8'h00, ok);
        nvec++;
        if (!ok) begin
            nerr++;
            $display("FAIL glitch_settle: sw_out=%h required 00", bus.sw_out);
        end
        bus.sw_in = 8'h08;
        for (int c = 0; c < 46; c++) begin
            if (c == 6) bus.sw_in = 8'h00;
            step();
            if (bus.sw_out !== 8'h00) bad_out++;
            if (bus.chg !== 1'b0) bad_chg++;
        end
        nvec++;
        if (bad_out != 0 || bad_chg != 0) begin
            nerr++;
            $display("FAIL glitch_single: bad_out=%0d bad_chg=%0d required 0 0", bad_out, bad_chg);
        end
        bad_out = 0;
        bad_chg = 0;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 8; c++) begin
                bus.sw_in = (c < 4) ? 8'h08 : 8'h00;
                step();
                if (bus.sw_out !== 8'h00) bad_out++;
                if (bus.chg !== 1'b0) bad_chg++;
            end
        end
        repeat (20) begin
            step();
            if (bus.sw_out !== 8'h00) bad_out++;
            if (bus.chg !== 1'b0) bad_chg++;
        end
        nvec++;
        if (bad_out != 0 || bad_chg != 0) begin
            nerr++;
            $display("FAIL glitch_bounce: bad_out=%0d bad_chg=%0d required 0 0", bad_out, bad_chg);
        end
    endtask

    task automatic test_multi_bit();
        int t0 = -1, t7 = -1, pulses = 0;
        bus.sw_in = 8'h81;
        for (int c = 1; c <= 40; c++) begin
            step();
            if (bus.chg === 1'b1) pulses++;
            if (t0 < 0 && bus.sw_out[0] === 1'b1) t0 = c;
            if (t7 < 0 && bus.sw_out[7] === 1'b1) t7 = c;
        end
        nvec++;
        if (t0 != t7 || t0 < 11 || t0 > 14) begin
            nerr++;
            $display("FAIL multi_same_cycle: bit0@%0d bit7@%0d required equal in 11..14", t0, t7);
        end
        nvec++;
        if (pulses != 1) begin
            nerr++;
            $display("FAIL multi_chg: pulses=%0d required 1", pulses);
        end
        nvec++;
        if (bus.sw_out !== 8'h81 || enc8(bus.sw_out) !== 3'b111) begin
            nerr++;
            $display("FAIL multi_encode: sw_out=%h y=%b required 81 y=111", bus.sw_out, enc8(bus.sw_out));
        end
    endtask

    task automatic test_reset_mid_count();
        int first = -1, early = 0;
        rst_n = 1'b0;
        #1;
        nvec++;
        if (bus.sw_out !== 8'h00 || bus.chg !== 1'b0) begin
            nerr++;
            $display("FAIL async_reset: sw_out=%h chg=%b required 00 0", bus.sw_out, bus.chg);
        end
        bus.sw_in = 8'h10;
        step();
        step();
        rst_n = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            step();
            if (bus.sw_out !== 8'h00) early++;
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (first < 0 && bus.sw_out === 8'h10) first = c;
        end
        nvec++;
        if (early != 0) begin
            nerr++;
            $display("FAIL midcount_early: early=%0d required 0", early);
        end
        nvec++;
        if (first != 12) begin
            nerr++;
            $display("FAIL midcount_restart: cycles=%0d required 12", first);
        end
    endtask

`ifdef SW_DEBOUNCE_RISE_EN
    task automatic test_rise();
        bit ok;
        int rise_cnt = 0, chg_cnt = 0;
        logic [7:0] rise_val = 8'h00;
        settle(8'h00, ok);
        nvec++;
        if (!ok) begin
            nerr++;
            $display("FAIL rise_settle: sw_out=%h required 00", bus.sw_out);
        end
        bus.sw_in = 8'h04;
        for (int c = 0; c < 30; c++) begin
            step();
            if (bus.rise !== 8'h00) begin rise_cnt++; rise_val = bus.rise; end
            if (bus.chg === 1'b1) chg_cnt++;
        end
        nvec++;
        if (rise_cnt != 1 || rise_val !== 8'h04 || chg_cnt != 1) begin
            nerr++;
            $display("FAIL rise_up: cycles=%0d rise=%h chg=%0d required 1 04 1", rise_cnt, rise_val, chg_cnt);
        end
        rise_cnt = 0;
        chg_cnt  = 0;
        bus.sw_in = 8'h00;
        for (int c = 0; c < 30; c++) begin
            step();
            if (bus.rise !== 8'h00) rise_cnt++;
            if (bus.chg === 1'b1) chg_cnt++;
        end
        nvec++;
        if (rise_cnt != 0 || chg_cnt != 1 || bus.sw_out !== 8'h00) begin
            nerr++;
            $display("FAIL rise_down: rise_cycles=%0d chg=%0d sw_out=%h required 0 1 00", rise_cnt, chg_cnt, bus.sw_out);
        end
    endtask
`endif

    initial begin
        rst_n     = 1'b0;
        bus.sw_in = 8'hFF;
        test_reset();
        test_clean_step();
        test_glitch();
        test_multi_bit();
        test_reset_mid_count();
`ifdef SW_DEBOUNCE_RISE_EN
        test_rise();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
